// File: rtl/sram_pattern_test.sv
// Built-in self test for an asynchronous SRAM: ADD, ADDRESS and MARCH patterns.
// One address operation at a time: write, read, or read-modify-write on the same address.
module sram_pattern_test #(
    parameter int              AW          = 21,
    parameter int              DW          = 8,
    parameter logic [AW-1:0]   END_ADDRESS = 21'h07FFFF,
    parameter int              WE_CYCLES   = 1,
    parameter int              RD_WAIT     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [AW-1:0] sram_a,
    inout  wire  [DW-1:0] sram_d,
    output logic          sram_we_n,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_expected,
    output logic [DW-1:0] fail_data
);

    localparam int CW = 16;
    localparam logic [1:0] OP_W = 2'd0, OP_RMW = 2'd1, OP_R = 2'd2;

    // 0x55 replicated to any data width: even bits set
    function automatic logic [DW-1:0] pat55();
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = (i % 2 == 0);
        return r;
    endfunction
    localparam logic [DW-1:0] PAT = pat55();

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WSETUP, S_WLOW, S_WHOLD, S_RSV} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d, fa_q, fa_d;
    logic [1:0]    pass_q, pass_d, mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] wdata_q, wdata_d, fe_q, fe_d, fd_q, fd_d;
    logic          busy_q, busy_d, done_q, done_d, ok_q, ok_d;

    logic [1:0]    op, last;
    logic [DW-1:0] wval, expv, a_low, addr_pat;
    logic          cmp_en, desc, at_end, advance, flip;

    if (AW > DW) begin : g_flip
        assign flip = a_q[DW];
    end else begin : g_noflip
        assign flip = 1'b0;
    end
    assign a_low    = DW'(a_q);
    assign addr_pat = a_low ^ {DW{flip}};

    always_comb begin
        op     = OP_W;
        wval   = '0;
        expv   = '0;
        cmp_en = 1'b0;
        case ({mode_q, pass_q})
            {2'd0, 2'd0}: wval = PAT;
            {2'd0, 2'd1}: begin op = OP_RMW; wval = sram_d + PAT; end
            {2'd0, 2'd2}: begin op = OP_R; cmp_en = 1'b1; expv = PAT + PAT; end
            {2'd1, 2'd0}: wval = addr_pat;
            {2'd1, 2'd1}: begin op = OP_R; cmp_en = 1'b1; expv = addr_pat; end
            {2'd2, 2'd0}: wval = '0;
            {2'd2, 2'd1}: begin op = OP_RMW; cmp_en = 1'b1; expv = '0; wval = '1; end
            {2'd2, 2'd2}: begin op = OP_RMW; cmp_en = 1'b1; expv = '1; wval = '0; end
            {2'd2, 2'd3}: begin op = OP_R; cmp_en = 1'b1; expv = '0; end
            default: ;
        endcase
        last   = (mode_q == 2'd0) ? 2'd2 : (mode_q == 2'd1) ? 2'd1 : 2'd3;
        desc   = (mode_q == 2'd2) && (pass_q == 2'd2);
        at_end = desc ? (a_q == '0) : (a_q == END_ADDRESS);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        pass_d  = pass_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ok_d    = ok_q;
        fa_d    = fa_q;
        fe_d    = fe_q;
        fd_d    = fd_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                mode_d  = mode;
                pass_d  = '0;
                a_d     = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                ok_d    = 1'b0;
                fa_d    = '0;
                fe_d    = '0;
                fd_d    = '0;
                state_d = (mode == 2'd3) ? S_RSV : S_WSETUP;
            end
            S_RSV: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_WSETUP: begin
                wdata_d = wval;
                cnt_d   = CW'(WE_CYCLES - 1);
                state_d = S_WLOW;
            end
            S_WLOW: begin
                if (cnt_q == '0) state_d = S_WHOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WHOLD: advance = 1'b1;
            S_READ: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (cmp_en && (sram_d != expv)) begin
                    fa_d    = a_q;
                    fe_d    = expv;
                    fd_d    = sram_d;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (op == OP_RMW) begin
                    // read cycles double as the write setup, so go straight to the pulse
                    wdata_d = wval;
                    cnt_d   = CW'(WE_CYCLES - 1);
                    state_d = S_WLOW;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (at_end && (pass_q == last)) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ok_d    = 1'b1;
            end else if (at_end) begin
                pass_d  = pass_q + 2'd1;
                a_d     = (mode_q == 2'd2 && pass_q == 2'd1) ? END_ADDRESS : '0;
                cnt_d   = CW'(RD_WAIT);
                state_d = S_READ;
            end else begin
                a_d     = desc ? a_q - 1'b1 : a_q + 1'b1;
                cnt_d   = CW'(RD_WAIT);
                state_d = (op == OP_W) ? S_WSETUP : S_READ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            pass_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            fa_q    <= '0;
            fe_q    <= '0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            fa_q    <= fa_d;
            fe_q    <= fe_d;
            fd_q    <= fd_d;
        end
    end

    assign sram_we_n     = (state_q != S_WLOW);
    assign sram_d        = (state_q == S_WLOW) ? wdata_q : {DW{1'bz}};
    assign sram_a        = a_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = ok_q;
    assign fail_addr     = fa_q;
    assign fail_expected = fe_q;
    assign fail_data     = fd_q;

endmodule

// File: tb/tb_sram_pattern_test.sv
// Directed bench for sram_pattern_test with a 512-byte SRAM model and fault injection.
module tb_sram_pattern_test;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [20:0] sram_a;
    wire  [7:0]  sram_d;
    logic        sram_we_n, busy, done, pass;
    logic [20:0] fail_addr;
    logic [7:0]  fail_expected, fail_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_pattern_test #(
        .AW(21), .DW(8), .END_ADDRESS(21'd511), .WE_CYCLES(3), .RD_WAIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .sram_a(sram_a), .sram_d(sram_d), .sram_we_n(sram_we_n),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_data(fail_data)
    );

    // SRAM model: drives the bus whenever the DUT is not writing
    logic [7:0] mem [0:511];
    logic       alias_en = 1'b0;
    logic       stuck_en = 1'b0;
    logic [8:0] idx;
    logic [7:0] rdata;

    always_comb begin
        idx   = alias_en ? {1'b0, sram_a[7:0]} : sram_a[8:0];
        rdata = mem[idx] | {7'd0, (stuck_en && sram_a == 21'd5)};
    end
    assign sram_d = sram_we_n ? rdata : 8'hzz;

    always @(posedge clk) if (!sram_we_n) mem[idx] <= sram_d;

    // write pulse monitor
    int   low_cycles = 0, pulses = 0, pulse_bad = 0, low_len = 0;
    logic prev_we = 1'b1;
    logic [20:0] prev_a = '0;
    always @(negedge clk) begin
        if (sram_we_n === 1'b0) begin
            low_cycles++;
            if (sram_a !== prev_a) pulse_bad++;
            low_len = prev_we ? 1 : low_len + 1;
        end else if (prev_we === 1'b0) begin
            pulses++;
            if (low_len != 3 || sram_a !== prev_a) pulse_bad++;
        end
        prev_we = sram_we_n;
        prev_a  = sram_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_test(input logic [1:0] m, input string tag);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, busy, 1'b1);
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_addr0"}, sram_a, 21'd0);
    endtask

    // counts busy cycles until done; optionally fires a stray mode-3 start mid-run
    task automatic wait_done(input string tag, input bit inject, output int cyc);
        cyc = 1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) break;
            cyc++;
            if (inject && cyc == 100) begin start = 1'b1; mode = 2'd3; end
            if (inject && cyc == 101) begin start = 1'b0; mode = 2'd0; end
        end
        check({tag, "_finished"}, done, 1'b1);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_we_idle"}, sram_we_n, 1'b1);
    endtask

    int cyc, base_low, base_pulses, base_bad, bad_cnt;

    initial begin
        #3;
        check("rst_addr", sram_a, 21'd0);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_fails", {fail_addr, fail_expected, fail_data}, 37'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", busy, 1'b0);

        // mode 0, ideal SRAM, stray start during run
        base_pulses = pulses; base_bad = pulse_bad;
        start_test(2'd0, "add");
        wait_done("add", 1'b1, cyc);
        check("add_pass", pass, 1'b1);
        check("add_cycles", cyc, 7680);
        check("add_pulses", pulses - base_pulses, 1024);
        check("add_pulse_shape", pulse_bad - base_bad, 0);
        bad_cnt = 0;
        for (int a = 0; a < 512; a++) if (mem[a] !== 8'hAA) bad_cnt++;
        check("add_mem_aa", bad_cnt, 0);

        // mode 2, ideal SRAM, exercises descending pass
        start_test(2'd2, "march");
        wait_done("march", 1'b0, cyc);
        check("march_pass", pass, 1'b1);
        check("march_cycles", cyc, 11264);
        bad_cnt = 0;
        for (int a = 0; a < 512; a++) if (mem[a] !== 8'h00) bad_cnt++;
        check("march_mem_0", bad_cnt, 0);

        // mode 2, bit 0 stuck at 1 at address 5
        stuck_en = 1'b1;
        base_low = low_cycles;
        start_test(2'd2, "stuck");
        wait_done("stuck", 1'b0, cyc);
        check("stuck_pass", pass, 1'b0);
        check("stuck_addr", fail_addr, 21'd5);
        check("stuck_exp", fail_expected, 8'h00);
        check("stuck_data", fail_data, 8'h01);
        check("stuck_cycles", cyc, 2598);
        check("stuck_writes", low_cycles - base_low, 1551);
        repeat (20) @(negedge clk);
        check("stuck_no_more_writes", low_cycles - base_low, 1551);
        check("stuck_done_held", done, 1'b1);
        stuck_en = 1'b0;

        // mode 3 reserved: clears previous failure info
        start_test(2'd3, "rsv");
        wait_done("rsv", 1'b0, cyc);
        check("rsv_cycles", cyc, 1);
        check("rsv_pass", pass, 1'b0);
        check("rsv_fails", {fail_addr, fail_expected, fail_data}, 37'd0);

        // mode 1, ideal then aliased address bit 8
        start_test(2'd1, "addr");
        wait_done("addr", 1'b0, cyc);
        check("addr_pass", pass, 1'b1);
        check("addr_cycles", cyc, 4096);
        check("addr_mem_300", mem[300], 8'hD3);
        alias_en = 1'b1;
        start_test(2'd1, "alias");
        wait_done("alias", 1'b0, cyc);
        check("alias_pass", pass, 1'b0);
        check("alias_addr", fail_addr, 21'd0);
        check("alias_exp", fail_expected, 8'h00);
        check("alias_data", fail_data, 8'hFF);
        check("alias_cycles", cyc, 2563);
        alias_en = 1'b0;

        // reset in the middle of a write pulse
        start_test(2'd0, "rstw");
        for (int i = 0; i < 50; i++) begin
            if (sram_we_n === 1'b0) break;
            @(negedge clk);
        end
        check("rstw_in_pulse", sram_we_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_we_n", sram_we_n, 1'b1);
        check("rstw_busy", busy, 1'b0);
        check("rstw_addr", sram_a, 21'd0);
        check("rstw_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstw_idle", {busy, done, sram_we_n}, 3'b001);
        start_test(2'd0, "rerun");
        wait_done("rerun", 1'b0, cyc);
        check("rerun_pass", pass, 1'b1);
        check("rerun_cycles", cyc, 7680);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
